// File: rtl/sr_bank_pkg.sv
// -----------------------------------------------------------------------------
// sr_bank_pkg
// Shared definitions for the SR flag-bank controller and its arbiter.
//   OP_SET / OP_CLR : encoding of the per-requester operation bit.
//   state_t         : controller FSM states (ST_IDLE, ST_SWEEP).
//   CONFLICT_MAX    : saturation value of the optional redundant-op counter.
// -----------------------------------------------------------------------------
package sr_bank_pkg;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at requester
// 'ptr' and wraps modulo N; the first active request wins. The pointer
// register itself lives in the owning controller.
// Ports:
//   req    [N]  : request vector
//   ptr    [PW] : requester with highest priority this cycle (must be < N)
//   gnt    [N]  : one-hot grant, all zero when no request is active
//   winner [PW] : index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner
);

  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [PW:0] w_pos;
  logic        w_found;

  // w_pos carries one extra bit so ptr+k can exceed N before the wrap
  // subtraction; this keeps non power-of-two N correct.
  always_comb begin
    gnt     = '0;
    winner  = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, ptr} + (PW+1)'(k);
      if (w_pos >= NV) begin
        w_pos = w_pos - NV;
      end
      if (!w_found && req[w_pos[PW-1:0]]) begin
        w_found              = 1'b1;
        gnt[w_pos[PW-1:0]]   = 1'b1;
        winner               = w_pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// -----------------------------------------------------------------------------
// sr_bank_ctrl
// Single writer of a bank of NFLAGS set/reset flags. In IDLE it grants at most
// one set/clear request per cycle using round-robin priority; a clear_all
// pulse starts a sweep that clears one flag per cycle from index 0 upwards.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   req_valid    [NREQ]      : per-requester request valid
//   req_op       [NREQ]      : per-requester op, 1 = set, 0 = clear
//   req_idx      [NREQ*IDXW] : requester i uses bits [i*IDXW +: IDXW]
//   req_ready    [NREQ]      : one-hot grant, request consumed this cycle
//   clear_all    : pulse that starts a bank-clear sweep
//   flags        [NFLAGS]    : registered flag bank
//   busy         : high while a sweep is in progress
//   conflict_cnt [8]         : saturating count of granted redundant ops
//                              (present only with SR_BANK_CTRL_CONFLICT_EN)
//
// Build option: define SR_BANK_CTRL_CONFLICT_EN to add conflict_cnt.
// -----------------------------------------------------------------------------
module sr_bank_ctrl
  import sr_bank_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clear_all,
  output logic [NFLAGS-1:0]    flags,
`ifdef SR_BANK_CTRL_CONFLICT_EN
  output logic [7:0]           conflict_cnt,
`endif
  output logic                 busy
);

  localparam int              RRW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFLAGS - 1);
  localparam logic [RRW-1:0]  LAST_REQ = RRW'(NREQ - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [RRW-1:0]    r_ptr;
  logic [RRW-1:0]    w_ptrNext;
  logic [IDXW-1:0]   r_sweepIdx;
  logic [NFLAGS-1:0] r_flags;

  logic              w_arbEn;
  logic              w_sweepStart;
  logic [NREQ-1:0]   w_arbReq;
  logic [NREQ-1:0]   w_gnt;
  logic [RRW-1:0]    w_winner;
  logic              w_grant;
  logic              w_op;
  logic [IDXW-1:0]   w_idx;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and state-decoded controls. clear_all wins over requests in
  // IDLE, and is ignored once the sweep is running.
  always_comb begin
    w_nextState  = r_state;
    w_arbEn      = 1'b0;
    w_sweepStart = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_all) begin
          w_nextState  = ST_SWEEP;
          w_sweepStart = 1'b1;
        end else begin
          w_arbEn = 1'b1;
        end
      end
      ST_SWEEP: begin
        busy = 1'b1;
        if (r_sweepIdx == LAST_IDX) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // A grant during a reset cycle would be discarded by the reset edge, so
  // ready is held low to avoid telling a requester it was consumed.
  assign w_arbReq = req_valid & {NREQ{w_arbEn & ~reset}};

  rr_arbiter #(
    .N  (NREQ),
    .PW (RRW)
  ) u_arb (
    .req    (w_arbReq),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .winner (w_winner)
  );

  assign req_ready = w_gnt;
  assign w_grant   = |w_gnt;
  assign w_op      = req_op[w_winner];
  assign w_idx     = req_idx[int'(w_winner)*IDXW +: IDXW];
  assign w_ptrNext = (w_winner == LAST_REQ) ? '0 : w_winner + RRW'(1);

  // Flag bank, round-robin pointer and sweep index. The sweep index wraps
  // back to zero after the last flag because NFLAGS is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags    <= '0;
      r_ptr      <= '0;
      r_sweepIdx <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_flags[r_sweepIdx] <= OP_CLR;
      r_sweepIdx          <= r_sweepIdx + IDXW'(1);
    end else if (w_sweepStart) begin
      r_sweepIdx <= '0;
    end else if (w_grant) begin
      r_flags[w_idx] <= (w_op == OP_SET);
      r_ptr          <= w_ptrNext;
    end
  end

  assign flags = r_flags;

`ifdef SR_BANK_CTRL_CONFLICT_EN
  logic [7:0] r_conflictCnt;
  logic       w_redundant;

  assign w_redundant = w_grant && (w_op == r_flags[w_idx]);

  always_ff @(posedge clk) begin
    if (reset || w_sweepStart) begin
      r_conflictCnt <= '0;
    end else if (w_redundant && (r_conflictCnt != CONFLICT_MAX)) begin
      r_conflictCnt <= r_conflictCnt + 8'd1;
    end
  end

  assign conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_bank_ctrl
// Self-checking bench for sr_bank_ctrl (NREQ=4, NFLAGS=8, IDXW=3). A small
// behavioural model predicts grants, busy and the next flag value; predicted
// flag words are queued and compared one cycle later. Scenario tasks add
// directed checks with hand-derived constants.
// Define SR_BANK_CTRL_CONFLICT_EN to also exercise conflict_cnt.
// -----------------------------------------------------------------------------
module tb_sr_bank_ctrl;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;
  localparam int IDXW   = 3;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic                 clear_all;
  logic [NFLAGS-1:0]    flags;
  logic                 busy;
`ifdef SR_BANK_CTRL_CONFLICT_EN
  logic [7:0]           conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [NFLAGS-1:0] sbq[$];

  int                mPtr;
  int                mSweepIdx;
  int                mCnt;
  logic              mSweep;
  logic [NFLAGS-1:0] mFlags;

  logic [NREQ-1:0]   obsReady;
  logic [NFLAGS-1:0] obsFlags;
  logic              obsBusy;

  sr_bank_ctrl #(
    .NREQ   (NREQ),
    .NFLAGS (NFLAGS),
    .IDXW   (IDXW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_idx      (req_idx),
    .req_ready    (req_ready),
    .clear_all    (clear_all),
    .flags        (flags),
`ifdef SR_BANK_CTRL_CONFLICT_EN
    .conflict_cnt (conflict_cnt),
`endif
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arbitration: scan from the model pointer, wrapping modulo NREQ.
  function automatic int modelWinner();
    int i;
    if (reset || mSweep || clear_all) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (mPtr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic op, input int idx);
    req_valid[i]                = 1'b1;
    req_op[i]                   = op;
    req_idx[i*IDXW +: IDXW]     = IDXW'(idx);
  endtask

  // One clock: compare at the falling edge, advance the model, then drop the
  // valid of any requester whose transfer just completed.
  task automatic cycle();
    int                w;
    int                ix;
    logic [NREQ-1:0]   expReady;
    logic [NFLAGS-1:0] expFlags;
    @(negedge clk);
    obsReady = req_ready;
    obsFlags = flags;
    obsBusy  = busy;
    if (sbq.size() > 0) begin
      expFlags = sbq.pop_front();
      checks++;
      if (obsFlags !== expFlags) begin
        errors++;
        $display("[TB] FAIL sb_flags t=%0t got=%h want=%h", $time, obsFlags, expFlags);
      end
    end
    w = modelWinner();
    expReady = '0;
    if (w >= 0) expReady[w] = 1'b1;
    checks++;
    if (obsReady !== expReady) begin
      errors++;
      $display("[TB] FAIL sb_ready t=%0t got=%b want=%b", $time, obsReady, expReady);
    end
    checks++;
    if (obsBusy !== mSweep) begin
      errors++;
      $display("[TB] FAIL sb_busy t=%0t got=%b want=%b", $time, obsBusy, mSweep);
    end
`ifdef SR_BANK_CTRL_CONFLICT_EN
    checks++;
    if (conflict_cnt !== 8'(mCnt)) begin
      errors++;
      $display("[TB] FAIL sb_conflict t=%0t got=%0d want=%0d", $time, conflict_cnt, mCnt);
    end
`endif
    if (reset) begin
      mFlags = '0; mPtr = 0; mSweep = 1'b0; mSweepIdx = 0; mCnt = 0;
    end else if (mSweep) begin
      mFlags[mSweepIdx] = 1'b0;
      if (mSweepIdx == NFLAGS - 1) mSweep = 1'b0;
      else mSweepIdx++;
    end else if (clear_all) begin
      mSweep = 1'b1; mSweepIdx = 0; mCnt = 0;
    end else if (w >= 0) begin
      ix = int'(req_idx[w*IDXW +: IDXW]);
      if (mFlags[ix] == req_op[w] && mCnt < 255) mCnt++;
      mFlags[ix] = req_op[w];
      mPtr = (w + 1) % NREQ;
    end
    sbq.push_back(mFlags);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~obsReady;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_op = '1; req_idx = '0; clear_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mFlags = '0; mPtr = 0; mSweep = 1'b0; mSweepIdx = 0; mCnt = 0;
    cycle();
    checks++;
    if (obsFlags !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%h want=00", obsFlags);
    end
    checks++;
    if (obsReady !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b want=0000", obsReady);
    end
    reset = 1'b0; req_valid = '0;
    cycle();
  endtask

  task automatic test_single_set();
    setReq(0, 1'b1, 5);
    cycle();
    checks++;
    if (obsReady !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL set_ready got=%b want=0001", obsReady);
    end
    checks++;
    if (dut.r_ptr !== 2'd1) begin
      errors++;
      $display("[TB] FAIL set_ptr got=%0d want=1", dut.r_ptr);
    end
    cycle();
    checks++;
    if (obsFlags !== 8'h20) begin
      errors++;
      $display("[TB] FAIL set_flags got=%h want=20", obsFlags);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] e;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, i);
    for (int k = 0; k < NREQ; k++) begin
      cycle();
      e = '0; e[k] = 1'b1;
      checks++;
      if (obsReady !== e) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d got=%b want=%b", k, obsReady, e);
      end
    end
    cycle();
    checks++;
    if (obsFlags !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL rr_flags got=%h want=0F", obsFlags);
    end
  endtask

  task automatic test_sweep();
    logic [NFLAGS-1:0] e;
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, i + 4);
    repeat (NREQ) cycle();
    setReq(2, 1'b1, 6);
    clear_all = 1'b1;
    cycle();
    clear_all = 1'b0;
    checks++;
    if (obsReady !== 4'b0000 || obsFlags !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sweep_start ready=%b flags=%h want 0000/FF", obsReady, obsFlags);
    end
    for (int k = 0; k < NFLAGS; k++) begin
      cycle();
      e = 8'hFF << k;
      checks++;
      if (obsBusy !== 1'b1 || obsReady !== 4'b0000 || obsFlags !== e) begin
        errors++;
        $display("[TB] FAIL sweep_step%0d busy=%b ready=%b flags=%h want 1/0000/%h",
                 k, obsBusy, obsReady, obsFlags, e);
      end
    end
    cycle();
    checks++;
    if (obsBusy !== 1'b0 || obsReady !== 4'b0100 || obsFlags !== 8'h00) begin
      errors++;
      $display("[TB] FAIL sweep_end busy=%b ready=%b flags=%h want 0/0100/00",
               obsBusy, obsReady, obsFlags);
    end
    cycle();
    checks++;
    if (obsFlags !== 8'h40) begin
      errors++;
      $display("[TB] FAIL sweep_regrant got=%h want=40", obsFlags);
    end
  endtask

  task automatic test_same_flag();
    setReq(1, 1'b1, 7);
    cycle();
    checks++;
    if (dut.r_ptr !== 2'd2) begin
      errors++;
      $display("[TB] FAIL same_ptr got=%0d want=2", dut.r_ptr);
    end
    setReq(1, 1'b1, 7);
    setReq(3, 1'b0, 7);
    cycle();
    checks++;
    if (obsReady !== 4'b1000 || obsFlags[7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_first ready=%b f7=%b want 1000/1", obsReady, obsFlags[7]);
    end
    cycle();
    checks++;
    if (obsReady !== 4'b0010 || obsFlags[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_second ready=%b f7=%b want 0010/0", obsReady, obsFlags[7]);
    end
    cycle();
    checks++;
    if (obsFlags[7] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_final f7=%b want 1", obsFlags[7]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_all = 1'b1;
    cycle();
    clear_all = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (obsBusy !== 1'b0 || obsFlags !== 8'h00 || obsReady !== 4'b0000 || dut.r_ptr !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midsweep_reset busy=%b flags=%h ready=%b ptr=%0d want 0/00/0000/0",
               obsBusy, obsFlags, obsReady, dut.r_ptr);
    end
  endtask

  task automatic test_reset_mid_grant();
    setReq(0, 1'b1, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (obsReady !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midgrant_ready got=%b want=0000", obsReady);
    end
    cycle();
    checks++;
    if (obsReady !== 4'b0001 || obsFlags !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midgrant_retry ready=%b flags=%h want 0001/00", obsReady, obsFlags);
    end
    cycle();
    checks++;
    if (obsFlags !== 8'h08) begin
      errors++;
      $display("[TB] FAIL midgrant_flags got=%h want=08", obsFlags);
    end
  endtask

`ifdef SR_BANK_CTRL_CONFLICT_EN
  task automatic test_conflict();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      setReq(0, 1'b1, 2);
      cycle();
    end
    cycle();
    checks++;
    if (conflict_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL conflict_count got=%0d want=2", conflict_cnt);
    end
    clear_all = 1'b1;
    cycle();
    clear_all = 1'b0;
    cycle();
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL conflict_clear got=%0d want=0", conflict_cnt);
    end
    repeat (NFLAGS) cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_sweep();
    test_same_flag();
    test_reset_mid_sweep();
    test_reset_mid_grant();
`ifdef SR_BANK_CTRL_CONFLICT_EN
    test_conflict();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank_ctrl.md
Name: sr_bank_ctrl

Overview:
- Arbitrates set/clear requests from NREQ requesters onto a shared bank of NFLAGS set/reset flags. The bank is the registered equivalent of an array of enabled SR latches.
- Grants at most one operation per cycle, using round-robin priority.
- Sequences a multi-cycle sweep that clears the whole bank on request.
- Sits between control agents and the status-flag bank; it is the single writer of that bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAGS, 8, number of flags in the bank (power of 2, 2..64).
- IDXW, 3, flag index width; must equal log2(NFLAGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  NREQ  per-requester operation: 1 = set, 0 = clear.
- req_idx  in  NREQ*IDXW  per-requester flag index; requester i uses bits [i*IDXW +: IDXW].
- req_ready  out  NREQ  one-hot grant; the request is consumed this cycle.
- clear_all  in  1  pulse that starts a bank-clear sweep.
- flags  out  NFLAGS  registered flag bank contents.
- busy  out  1  high while a sweep is in progress.

Behaviour:
- Reset values: flags=0, req_ready=0, busy=0, rr pointer=0, state=IDLE, sweep index=0.
- FSM has two states.
  - IDLE: normal arbitration.
  - SWEEP: clears one flag per cycle, ascending from index 0.
- IDLE -> SWEEP on clear_all=1 at a clock edge.
  - In the cycle clear_all is high, req_ready=0 and no request is granted. clear_all has priority over requests.
- SWEEP -> IDLE after the cycle that clears index NFLAGS-1.
  - The sweep lasts exactly NFLAGS cycles. busy is high for those NFLAGS cycles.
  - clear_all is ignored during SWEEP; there is no restart.
- During SWEEP, req_ready=0 for all requesters. Requests stall and must hold valid/op/idx stable until granted.
- Arbitration in IDLE is combinational round-robin.
  - The search starts at the rr pointer and wraps modulo NREQ.
  - The first requester with req_valid=1 wins; req_ready[winner]=1 in the same cycle.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high.
  - Requester i may drop valid only after the transfer.
  - req_ready never asserts without valid.
- Flag update: on the edge ending a grant cycle, flags[idx] takes op (1 or 0).
  - flags reflects the update one cycle after the grant (latency 1).
  - Other flags are unchanged.
- rr pointer update:
  - On a grant, the pointer becomes (winner+1) mod NREQ.
  - With no grant it holds.
  - The pointer is not modified by a sweep.
- Simultaneous requests to the same flag from different requesters are serialized: the later grant wins, and flags shows each value for at least one cycle.
- Redundant ops (set an already-set flag, clear an already-clear flag) are legal no-ops but still consume a grant.
- Reset asserted mid-sweep or mid-grant: all state returns to reset values on that edge, and the pending grant is dropped.

Optional Feature:
- Macro SR_BANK_CTRL_CONFLICT_EN.
- Defined: adds output conflict_cnt[7:0].
  - Increments on each granted redundant op (op equals the current flags[idx]).
  - Saturates at 255.
  - Cleared by reset and at the start of a sweep.
- Undefined: the port and its logic are absent. Core behaviour is identical.

Decomposition:
- Package sr_bank_pkg holds:
  - op encoding constants OP_SET=1, OP_CLR=0;
  - FSM state typedef/constants ST_IDLE, ST_SWEEP.
- Sub-module rr_arbiter (params N): inputs req[N], ptr; outputs one-hot gnt[N] and winner index.
  - Purely combinational. The controller owns the pointer register.

Test Plan:
- Reset, then req 0: set idx 5 -> req_ready=0001 same cycle; flags=0x20 next cycle; rr pointer=1.
- All 4 requesters valid (set idx 0..3) -> grants in order 0,1,2,3 on consecutive cycles; flags=0x0F after 4 cycles.
- flags=0xFF, pulse clear_all with req 2 valid -> busy high for 8 cycles, flags drops one bit per cycle from bit 0; req 2 is granted in the first cycle after busy falls.
- Req 1 set idx 7 and req 3 clear idx 7 in the same cycle, pointer=2 -> req 3 is granted first (flags[7]=0), req 1 next (flags[7]=1).
- Assert reset during the 3rd sweep cycle -> next cycle busy=0, flags=0, pointer=0, no grant.
- With SR_BANK_CTRL_CONFLICT_EN: set idx 2 three times -> conflict_cnt=2; clear_all -> conflict_cnt=0.
